clk_div_switch: RTL
===================

// Module: clk_div_switch
// PURPOSE
//  Glitch-free programmable clock divider with runtime ratio switching.
//  Derives clk_o from clk at ratio 1 (bypass), 2..2^DIV_W-1 (divide) or 0 (stopped low).
//  Ratio changes take effect only at clock-phase boundaries, so clk_o never carries a runt pulse.
//  Sits beside clk_switch in the clock-generation tree and feeds downstream clock muxes.
// PARAMETERS
//  DIV_W        8   width of ratio field; max ratio 2^DIV_W-1
//  DEFAULT_DIV  2   ratio in force after reset (0 = stopped, 1 = bypass)
// PORTS
//  clk      in   1      source clock; only clock of the block
//  rst_n    in   1      asynchronous, active-low reset
//  div_req  in   1      ratio-change request, sampled on posedge clk
//  div_val  in   DIV_W  requested ratio, valid with div_req
//  div_ack  out  1      1-cycle pulse: new ratio applied this cycle
//  busy     out  1      request pending; div_req ignored while high
//  cur_div  out  DIV_W  ratio currently in force
//  clk_o    out  1      divided/gated output clock
// BEHAVIOUR
//  Reset: state LOW at terminal count, div_q=0, byp_en_n=0, clk_o=0, div_ack=0, busy=0,
//   cur_div=DEFAULT_DIV. Assertion clears clk_o asynchronously; a short pulse at reset is accepted.
//  Output: clk_o = div_q | (clk & byp_en_n). byp_en_n is the only negedge flop, so it changes
//   only while clk is low.
//  Ratio N>=2: H=N>>1 high cycles, then L=N-H low cycles (N=3: 1 high, 2 low).
//   div_q is registered on posedge.
//  Handshake: div_req & !busy latches div_val into pend and sets busy. div_req while busy is dropped.
//   Requester waits for div_ack.
//  Boundary: the posedge that ends a LOW phase. In BYP, every posedge. In STOP, the next posedge.
//   At a boundary with busy: cur_div<=pend, div_ack=1, busy<=0.
//  FSM states (posedge clk):
//   STOP: div_q=0. New 0 -> STOP. New 1 -> BYP. New >=2 -> HIGH.
//   HIGH: div_q=1. After H cycles -> LOW.
//   LOW: div_q=0. After L cycles (boundary) -> per cur_div: 0 STOP, 1 BYP, >=2 HIGH.
//   BYP: byp_req=1. Pending non-1 ratio: byp_req<=0, ack, -> GAP. Pending 1: ack only, stay.
//   GAP: one cycle, output low. -> HIGH (new >=2) or STOP (new 0).
//  Entering BYP from LOW: byp_en_n rises at the following negedge. First clk_o high is one clk period later.
//  Minimum clk_o high/low width: half clk period in every transition.
//  Same-value request: acked at the next boundary; waveform unchanged.
//  div_req in the same cycle as a boundary: pend is captured; applied at the following boundary.
//  Counter: DIV_W bits, reloads at each phase start, no wrap beyond phase length.
// STRUCTURE
//  clk_div_pkg: state encoding (STOP, HIGH, LOW, BYP, GAP), DIV_STOP=0, DIV_BYPASS=1.
//  Sub-module clk_gate_neg: negedge byp_en_n flop plus AND with clk.
//   Single instance; kept separate for timing constraints.
//  Top: posedge FSM, phase counter, handshake regs.
// TESTING
//  1 Reset release, DEFAULT_DIV=2: clk_o rises at posedge 1, period 2 clk, 50% duty.
//    cur_div=2.
//  2 Req 5 while running 2: ack at end of current low phase.
//    Then 2 clk high / 3 clk low. No clk_o pulse shorter than half clk.
//  3 Req 1 from ratio 4: ack at the boundary. clk_o low one extra cycle, then equals clk.
//    Req 3 then gives a GAP low cycle, then 1 high / 2 low.
//  4 Req 0 mid-HIGH: high phase completes, low phase completes, ack, clk_o held 0.
//    Req 2 then restarts at the next posedge.
//  5 Second div_req while busy=1: ignored, single ack, cur_div = first value.
//    Same-value req: ack, waveform unchanged.
//  6 rst_n low mid-HIGH at ratio 6: clk_o=0 immediately, busy=0.
//    After release, ratio returns to DEFAULT_DIV.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared state encoding and reserved ratio codes for the programmable clock divider.
package clk_div_pkg;

   typedef enum logic [2:0] {
      ST_STOP = 3'd0,
      ST_HIGH = 3'd1,
      ST_LOW  = 3'd2,
      ST_BYP  = 3'd3,
      ST_GAP  = 3'd4
   } div_state_e;

   localparam int DIV_STOP   = 0;
   localparam int DIV_BYPASS = 1;

endpackage

// File: rtl/clk_gate_neg.sv
// Bypass gate: negedge-registered enable ANDed with the source clock, so the
// enable only moves while clk is low and the gated clock cannot be chopped.
module clk_gate_neg (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic gclk_o
);

   logic byp_en_n_q;

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp_en_n_q <= 1'b0;
      end else begin
         byp_en_n_q <= en_i;
      end
   end

   assign gclk_o = clk & byp_en_n_q;

endmodule

// File: rtl/clk_div_switch.sv
// Glitch-free programmable clock divider; ratio changes are applied only at
// phase boundaries (end of a low phase, any cycle in bypass or stop).
import clk_div_pkg::*;

module clk_div_switch #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_req,
   input  logic [DIV_W-1:0] div_val,
   output logic             div_ack,
   output logic             busy,
   output logic [DIV_W-1:0] cur_div,
   output logic             clk_o
);

   localparam logic [DIV_W-1:0] RATIO_STOP = DIV_W'(DIV_STOP);
   localparam logic [DIV_W-1:0] RATIO_BYP  = DIV_W'(DIV_BYPASS);
   localparam logic [DIV_W-1:0] RESET_DIV  = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] ONE        = DIV_W'(1);

   div_state_e       state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             div_q, div_d;
   logic             byp_req_q, byp_req_d;
   logic [DIV_W-1:0] cur_div_q, cur_div_d;
   logic [DIV_W-1:0] pend_q, pend_d;
   logic             busy_q, busy_d;
   logic             ack_q, ack_d;
   logic             boundary, apply, restart;
   logic [DIV_W-1:0] start_div;
   logic             gclk;

   // Counter holds cycles remaining in the phase minus one; zero marks the last cycle.
   function automatic logic [DIV_W-1:0] highLast(input logic [DIV_W-1:0] n);
      return (n >> 1) - ONE;
   endfunction

   function automatic logic [DIV_W-1:0] lowLast(input logic [DIV_W-1:0] n);
      return n - (n >> 1) - ONE;
   endfunction

   always_comb begin
      boundary = 1'b0;
      case (state_q)
         ST_STOP, ST_BYP: boundary = 1'b1;
         ST_LOW:          boundary = (cnt_q == '0);
         default:         boundary = 1'b0;
      endcase
      apply     = boundary & busy_q;
      start_div = apply ? pend_q : cur_div_q;
   end

   // Next phase; leaving bypass always passes through GAP so the last bypass
   // pulse ends before the divider drives high again.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      restart = 1'b0;
      case (state_q)
         ST_HIGH: begin
            if (cnt_q == '0) begin
               state_d = ST_LOW;
               cnt_d   = lowLast(cur_div_q);
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         ST_LOW: begin
            if (cnt_q == '0) begin
               restart = 1'b1;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         ST_STOP, ST_GAP: restart = 1'b1;
         ST_BYP: begin
            if (apply && (pend_q != RATIO_BYP)) begin
               state_d = ST_GAP;
            end
         end
         default: state_d = ST_STOP;
      endcase
      if (restart) begin
         if (start_div == RATIO_STOP) begin
            state_d = ST_STOP;
         end else if (start_div == RATIO_BYP) begin
            state_d = ST_BYP;
         end else begin
            state_d = ST_HIGH;
            cnt_d   = highLast(start_div);
         end
      end
      div_d     = (state_d == ST_HIGH);
      byp_req_d = (state_d == ST_BYP);
   end

   always_comb begin
      cur_div_d = cur_div_q;
      pend_d    = pend_q;
      busy_d    = busy_q;
      ack_d     = 1'b0;
      if (apply) begin
         cur_div_d = pend_q;
         busy_d    = 1'b0;
         ack_d     = 1'b1;
      end else if (div_req && !busy_q) begin
         pend_d = div_val;
         busy_d = 1'b1;
      end
   end

   // Reset parks in the last cycle of a low phase so the first posedge starts the default ratio.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_LOW;
         cnt_q     <= '0;
         div_q     <= 1'b0;
         byp_req_q <= 1'b0;
         cur_div_q <= RESET_DIV;
         pend_q    <= '0;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         byp_req_q <= byp_req_d;
         cur_div_q <= cur_div_d;
         pend_q    <= pend_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
      end
   end

   clk_gate_neg uGate (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (byp_req_q),
      .gclk_o (gclk)
   );

   assign clk_o   = div_q | gclk;
   assign div_ack = ack_q;
   assign busy    = busy_q;
   assign cur_div = cur_div_q;

endmodule
